// File: rtl/ps2_device_port.sv
// ============================================================================
// ps2_device_port : device-side PS/2 transceiver (generates PS2_CLK, sends
//                   bytes to the host, receives host commands and acks them)
// Revision 1.0
// ============================================================================
`default_nettype none

module ps2_device_port #(
  parameter int HALF_PERIOD = 2000,
  parameter int SETUP       = 250,
  parameter int IDLE_HOLD   = 2500,
  parameter int CNT_W       = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       tx_aborted,
  output logic       busy,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TX_BIT    = 3'd1,
    S_RX_BIT    = 3'd2,
    S_RX_ACK    = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_LOW   = 2'd1,
    PH_HIGH  = 2'd2
  } phase_t;

  // Counter reload values; the counter runs down and a phase ends at zero.
  localparam logic [CNT_W-1:0] c_half    = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_high_tx = CNT_W'(HALF_PERIOD - SETUP - 1);
  localparam logic [CNT_W-1:0] c_setup   = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] c_idle    = CNT_W'(IDLE_HOLD - 1);
  localparam logic [CNT_W-1:0] c_sample  = CNT_W'(HALF_PERIOD - 1 - HALF_PERIOD / 2);
  localparam logic [3:0]       c_last    = 4'd10;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       tx_frame_q, tx_frame_d;
  logic [9:0]       tx_sh_q, tx_sh_d;
  logic             pending_q, pending_d;
  logic [9:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             perr_q, perr_d;
  logic             rx_valid_q, rx_valid_d;
  logic             ferr_q, ferr_d;
  logic             abort_q, abort_d;
  logic             clk_drv_q, clk_drv_d;
  logic             dat_drv_q, dat_drv_d;
  logic             ready_en_q;
  logic [1:0]       clk_sync_q, dat_sync_q;

  logic             w_clk_s, w_dat_s, w_tx_fire, w_done;
  logic [CNT_W-1:0] w_cnt_dec;

  assign PS2_CLK = clk_drv_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_drv_q ? 1'b0 : 1'bz;

  assign w_clk_s   = clk_sync_q[1];
  assign w_dat_s   = dat_sync_q[1];
  assign w_done    = (cnt_q == '0);
  assign w_cnt_dec = cnt_q - CNT_W'(1);

  assign tx_ready      = ready_en_q & (state_q == S_IDLE) & ~pending_q;
  assign w_tx_fire     = tx_valid & tx_ready;
  assign busy          = (state_q != S_IDLE);
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign tx_aborted    = abort_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_frame_d = tx_frame_q;
    tx_sh_d    = tx_sh_q;
    pending_d  = pending_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    perr_d     = perr_q;
    rx_valid_d = 1'b0;
    ferr_d     = 1'b0;
    abort_d    = 1'b0;
    clk_drv_d  = clk_drv_q;
    dat_drv_d  = dat_drv_q;

    // Frame held as {stop, odd parity, data}; the start bit is implicit.
    if (w_tx_fire) begin
      tx_frame_d = {1'b1, ~^tx_data, tx_data};
      pending_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (w_clk_s && !w_dat_s) begin
          state_d   = S_RX_BIT;
          phase_d   = PH_LOW;
          cnt_d     = c_half;
          bit_d     = 4'd0;
          clk_drv_d = 1'b1;
        end else if (!(w_clk_s && w_dat_s)) begin
          cnt_d = c_idle;
        end else if (!w_done) begin
          cnt_d = w_cnt_dec;
        end else if (pending_q) begin
          state_d   = S_TX_BIT;
          phase_d   = PH_SETUP;
          cnt_d     = c_setup;
          bit_d     = 4'd0;
          tx_sh_d   = tx_frame_q;
          dat_drv_d = 1'b1;
        end
      end

      S_TX_BIT: begin
        if (!w_done) begin
          cnt_d = w_cnt_dec;
        end else begin
          case (phase_q)
            PH_SETUP: begin
              if (!w_clk_s) begin
                clk_drv_d = 1'b0;
                dat_drv_d = 1'b0;
                abort_d   = 1'b1;
                state_d   = S_WAIT_IDLE;
              end else begin
                clk_drv_d = 1'b1;
                phase_d   = PH_LOW;
                cnt_d     = c_half;
              end
            end
            PH_LOW: begin
              clk_drv_d = 1'b0;
              phase_d   = PH_HIGH;
              // Next bit's setup time is carved out of this high phase.
              cnt_d     = (bit_q == c_last) ? c_half : c_high_tx;
            end
            default: begin
              if (bit_q == c_last) begin
                dat_drv_d = 1'b0;
                pending_d = 1'b0;
                state_d   = S_WAIT_IDLE;
              end else begin
                bit_d     = bit_q + 4'd1;
                dat_drv_d = ~tx_sh_q[0];
                tx_sh_d   = {1'b0, tx_sh_q[9:1]};
                phase_d   = PH_SETUP;
                cnt_d     = c_setup;
              end
            end
          endcase
        end
      end

      S_RX_BIT: begin
        if (phase_q == PH_HIGH && cnt_q == c_sample)
          rx_sh_d = {w_dat_s, rx_sh_q[9:1]};
        if (!w_done) begin
          cnt_d = w_cnt_dec;
        end else if (phase_q == PH_LOW) begin
          clk_drv_d = 1'b0;
          phase_d   = PH_HIGH;
          cnt_d     = c_half;
        end else if (bit_q != c_last) begin
          bit_d     = bit_q + 4'd1;
          clk_drv_d = 1'b1;
          phase_d   = PH_LOW;
          cnt_d     = c_half;
        end else if (rx_sh_q[9]) begin
          state_d   = S_RX_ACK;
          phase_d   = PH_SETUP;
          cnt_d     = c_setup;
          dat_drv_d = 1'b1;
        end else begin
          ferr_d  = 1'b1;
          state_d = S_WAIT_IDLE;
        end
      end

      S_RX_ACK: begin
        if (!w_done) begin
          cnt_d = w_cnt_dec;
        end else begin
          case (phase_q)
            PH_SETUP: begin
              clk_drv_d = 1'b1;
              phase_d   = PH_LOW;
              cnt_d     = c_half;
            end
            PH_LOW: begin
              clk_drv_d = 1'b0;
              phase_d   = PH_HIGH;
              cnt_d     = c_half;
            end
            default: begin
              dat_drv_d  = 1'b0;
              rx_valid_d = 1'b1;
              rx_data_d  = rx_sh_q[7:0];
              perr_d     = ~^rx_sh_q[8:0];
              state_d    = S_WAIT_IDLE;
            end
          endcase
        end
      end

      S_WAIT_IDLE: begin
        if (w_clk_s && w_dat_s) begin
          state_d = S_IDLE;
          cnt_d   = c_idle;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = c_idle;
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_SETUP;
      cnt_q      <= c_idle;
      bit_q      <= 4'd0;
      tx_frame_q <= '0;
      tx_sh_q    <= '0;
      pending_q  <= 1'b0;
      rx_sh_q    <= '0;
      rx_data_q  <= 8'h00;
      perr_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      abort_q    <= 1'b0;
      clk_drv_q  <= 1'b0;
      dat_drv_q  <= 1'b0;
      ready_en_q <= 1'b0;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_frame_q <= tx_frame_d;
      tx_sh_q    <= tx_sh_d;
      pending_q  <= pending_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      perr_q     <= perr_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      abort_q    <= abort_d;
      clk_drv_q  <= clk_drv_d;
      dat_drv_q  <= dat_drv_d;
      ready_en_q <= 1'b1;
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_device_port.sv
// ============================================================================
// tb_ps2_device_port : directed bench with a PS/2 host model on pulled-up lines
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ps2_device_port;

  localparam int HALF    = 20;
  localparam int SETUP_P = 5;
  localparam int IDLE_H  = 30;
  localparam int CW      = 8;
  localparam int TMO     = 400;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, rx_parity_err, rx_frame_err, tx_aborted, busy;
  logic [7:0] rx_data;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;
  wire        ps2_clk;
  wire        ps2_dat;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_device_port #(
    .HALF_PERIOD(HALF), .SETUP(SETUP_P), .IDLE_HOLD(IDLE_H), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .tx_aborted(tx_aborted), .busy(busy),
    .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rxv_cnt = 0, ferr_cnt = 0, abort_cnt = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_perr = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt  = rxv_cnt + 1;
      cap_data = rx_data;
      cap_perr = rx_parity_err;
    end
    if (rx_frame_err) ferr_cnt = ferr_cnt + 1;
    if (tx_aborted) abort_cnt = abort_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns once the requested PS2_CLK edge is seen; n = negedges waited.
  task automatic wait_edge(input bit rising, output bit ok, output int n);
    logic prev, cur;
    prev = ps2_clk;
    ok   = 1'b0;
    n    = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      cur = ps2_clk;
      n   = i + 1;
      if (rising ? (!prev && cur) : (prev && !cur)) begin
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
  endtask

  task automatic host_recv(output logic [10:0] fr, output int first_gap,
                           output int lo_min, output int lo_max,
                           output int hi_min, output int hi_max, output bit ok);
    bit e;
    int n;
    ok = 1'b1; fr = '0; first_gap = 0;
    lo_min = 1 << 30; lo_max = 0; hi_min = 1 << 30; hi_max = 0;
    for (int k = 0; k < 11; k++) begin
      wait_edge(1'b0, e, n);
      if (!e) begin ok = 1'b0; return; end
      if (k == 0) first_gap = n;
      else begin
        if (n < hi_min) hi_min = n;
        if (n > hi_max) hi_max = n;
      end
      fr[k] = ps2_dat;
      wait_edge(1'b1, e, n);
      if (!e) begin ok = 1'b0; return; end
      if (n < lo_min) lo_min = n;
      if (n > lo_max) lo_max = n;
    end
  endtask

  task automatic host_rts();
    host_clk_low = 1'b1;
    repeat (60) @(negedge clk);
    host_dat_low = 1'b1;
    repeat (5) @(negedge clk);
    host_clk_low = 1'b0;
  endtask

  task automatic host_send(input logic [7:0] d, input bit par, input bit stop,
                           input bit do_rts, output bit ack, output bit ok);
    logic [10:0] fr;
    bit e;
    int n;
    fr  = {stop, par, d, 1'b0};
    ok  = 1'b1;
    ack = 1'b0;
    if (do_rts) host_rts();
    for (int k = 0; k < 11; k++) begin
      wait_edge(1'b0, e, n);
      if (!e) begin ok = 1'b0; host_dat_low = 1'b0; return; end
      host_dat_low = !fr[k];
    end
    if (stop) begin
      wait_edge(1'b0, e, n);
      if (!e) begin ok = 1'b0; return; end
      ack = !ps2_dat;
      wait_edge(1'b1, e, n);
      if (!e) ok = 1'b0;
      repeat (HALF + 4) @(negedge clk);
    end else begin
      wait_edge(1'b1, e, n);
      if (!e) ok = 1'b0;
      repeat (HALF + 4) @(negedge clk);
      host_dat_low = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    ok       = 1'b0;
    for (int j = 0; j < TMO; j++) begin
      if (tx_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int j = 0; j < TMO; j++) begin
      @(negedge clk);
      if (!busy && ps2_clk && ps2_dat) begin ok = 1'b1; break; end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    bit         is_tx;
    logic [7:0] data;
    bit         par;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_par;
    bit         exp_perr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [10:0] fr;
    int          gap, lmin, lmax, hmin, hmax, rxb, fb, ab;
    bit          ok, ack, hs_ok;
    string       tag;

    //            is_tx data   par  stop exp_d  e_par e_perr
    vecs[0] = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'hF4, 1'b0, 1'b1, 8'hF4, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hF4, 1'b1, 1'b1, 8'hF4, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h55, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset tx_ready", 32'(tx_ready), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset busy", 32'(busy), 32'd0);
    check("reset pulses", {29'd0, rx_valid, rx_frame_err, tx_aborted}, 32'd0);
    check("reset lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    reset_n = 1'b1;
    #1 check("tx_ready at release", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("tx_ready one cycle after release", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      tag = $sformatf("vec%0d", i);
      if (vecs[i].is_tx) begin
        send_byte(vecs[i].data, hs_ok);
        check({tag, " handshake"}, 32'(hs_ok), 32'd1);
        host_recv(fr, gap, lmin, lmax, hmin, hmax, ok);
        check({tag, " frame complete"}, 32'(ok), 32'd1);
        check({tag, " start/stop"}, {30'd0, fr[10], fr[0]}, 32'd2);
        check({tag, " data"}, 32'(fr[8:1]), 32'(vecs[i].exp_data));
        check({tag, " parity"}, 32'(fr[9]), 32'(vecs[i].exp_par));
        check({tag, " low period"}, 32'(lmin + lmax), 32'(2 * HALF));
        check({tag, " high period"}, 32'(hmin + hmax), 32'(2 * HALF));
        check({tag, " tx_ready low in frame"}, 32'(tx_ready), 32'd0);
        wait_idle({tag, " idle"});
        @(negedge clk);
        check({tag, " tx_ready back"}, 32'(tx_ready), 32'd1);
      end else begin
        rxb = rxv_cnt;
        fb  = ferr_cnt;
        host_send(vecs[i].data, vecs[i].par, vecs[i].stop, 1'b1, ack, ok);
        check({tag, " host timing"}, 32'(ok), 32'd1);
        check({tag, " rx_valid pulses"}, 32'(rxv_cnt - rxb), 32'(vecs[i].stop));
        check({tag, " frame_err pulses"}, 32'(ferr_cnt - fb), 32'(!vecs[i].stop));
        check({tag, " rx_data"}, 32'(rx_data), 32'(vecs[i].exp_data));
        if (vecs[i].stop) begin
          check({tag, " ack"}, 32'(ack), 32'd1);
          check({tag, " parity_err"}, 32'(cap_perr), 32'(vecs[i].exp_perr));
          check({tag, " captured data"}, 32'(cap_data), 32'(vecs[i].exp_data));
        end
        wait_idle({tag, " idle"});
      end
    end

    // Host inhibit during bit 4 of 0xAA, then full resend.
    ab = abort_cnt;
    send_byte(8'hAA, hs_ok);
    check("inhibit handshake", 32'(hs_ok), 32'd1);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_edge(1'b0, ack, gap);
      ok = ok & ack;
      wait_edge(1'b1, ack, gap);
      ok = ok & ack;
    end
    check("inhibit first bits", 32'(ok), 32'd1);
    host_clk_low = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    check("tx_aborted pulse", 32'(abort_cnt - ab), 32'd1);
    check("inhibit data released", 32'(ps2_dat), 32'd1);
    check("inhibit byte pending", 32'(tx_ready), 32'd0);
    host_clk_low = 1'b0;
    host_recv(fr, gap, lmin, lmax, hmin, hmax, ok);
    check("resend complete", 32'(ok), 32'd1);
    check("resend idle hold", 32'((gap >= IDLE_H + SETUP_P) && (gap <= IDLE_H + SETUP_P + 4)), 32'd1);
    check("resend frame", 32'(fr), 32'({1'b1, 1'b1, 8'hAA, 1'b0}));
    wait_idle("resend idle");

    // Collision: tx handshake lands in the request-to-send detection cycle.
    rxb = rxv_cnt;
    host_rts();
    tx_data = 8'h01;
    fork
      begin
        @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b1;
        hs_ok = 1'b0;
        for (int j = 0; j < TMO; j++) begin
          if (tx_ready) begin hs_ok = 1'b1; break; end
          @(negedge clk);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
      host_send(8'hFF, 1'b1, 1'b1, 1'b0, ack, ok);
    join
    check("collision handshake", 32'(hs_ok), 32'd1);
    check("collision rx ok", 32'(ok), 32'd1);
    check("collision ack", 32'(ack), 32'd1);
    check("collision rx_valid", 32'(rxv_cnt - rxb), 32'd1);
    check("collision rx_data", 32'(cap_data), 32'hFF);
    check("collision byte held", 32'(tx_ready), 32'd0);
    host_recv(fr, gap, lmin, lmax, hmin, hmax, ok);
    check("collision tx complete", 32'(ok), 32'd1);
    check("collision tx frame", 32'(fr), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
    wait_idle("collision idle");

    // Reset asserted while the device is driving a receive clock low.
    rxb = rxv_cnt;
    host_rts();
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_edge(1'b0, ack, gap);
      ok = ok & ack;
    end
    check("mid-receive reached", 32'({ok, ps2_clk}), 32'd2);
    reset_n      = 1'b0;
    host_dat_low = 1'b0;
    #1;
    check("reset lines released", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data cleared", 32'(rx_data), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("tx_ready after re-release", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("tx_ready one cycle later", 32'(tx_ready), 32'd1);
    check("no rx_valid from aborted frame", 32'(rxv_cnt - rxb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
